// File: rtl/spike_event_arbiter_if.sv
// Output event stream of the spike arbiter: valid/ready handshake carrying a channel index.
interface spike_event_arbiter_if #(
    parameter int unsigned CH_W = 4
) ();
    logic            out_valid;
    logic [CH_W-1:0] out_channel;
    logic            out_ready;

    modport master (output out_valid, output out_channel, input out_ready);
    modport slave  (input out_valid, input out_channel, output out_ready);
endinterface

// File: rtl/spike_event_arbiter.sv
// Round-robin merge of per-channel spike pulses into one valid/ready event stream.
// Define SPIKE_ARB_DROP_CNT_EN to build the per-channel saturating drop counters.
module spike_event_arbiter #(
    parameter int unsigned N_CH   = 16,
    parameter int unsigned CH_W   = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       spike_in,
    input  logic [N_CH-1:0]       ch_enable,
    input  logic                  flush,
    spike_event_arbiter_if.master evt,
    output logic [N_CH-1:0]       pending,
    output logic                  any_drop,
    input  logic [CH_W-1:0]       drop_sel,
    output logic [DROP_W-1:0]     drop_count,
    input  logic                  drop_clr
);

    logic [N_CH-1:0] spk;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] gnt;
    logic [N_CH-1:0] drop;
    logic [N_CH-1:0] pending_nxt;
    logic            load;
    logic            grant_vld;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] rr_ptr;
    logic            out_valid;
    logic [CH_W-1:0] out_channel;

    assign evt.out_valid   = out_valid;
    assign evt.out_channel = out_channel;

    // A spike arriving this cycle competes immediately (bypass into the request vector).
    assign spk  = spike_in & ch_enable;
    assign req  = pending | spk;
    assign load = !out_valid || evt.out_ready;

    // First requester at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin : rr_pick
        int unsigned k;
        grant_vld = 1'b0;
        grant_idx = '0;
        k         = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            k = 32'(rr_ptr) + i;
            if (k >= N_CH) k = k - N_CH;
            if (!grant_vld && req[CH_W'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(k);
            end
        end
    end

    assign gnt         = (load && grant_vld) ? (N_CH'(1) << grant_idx) : '0;
    assign drop        = spk & pending & ~gnt;
    // A granted pending channel re-arms on a same-cycle spike; a bypassed spike does not.
    assign pending_nxt = (pending & ~gnt) | (spk & ~(gnt & ~pending));

    always_ff @(posedge clk or negedge rst_n) begin : arb_state
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            rr_ptr      <= '0;
            pending     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            pending   <= '0;
        end else begin
            pending <= pending_nxt;
            if (load) begin
                out_valid <= grant_vld;
                if (grant_vld) begin
                    out_channel <= grant_idx;
                    rr_ptr      <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : drop_flag
        if (!rst_n) begin
            any_drop <= 1'b0;
        end else if (drop_clr) begin
            any_drop <= 1'b0;
        end else if (!flush && (|drop)) begin
            any_drop <= 1'b1;
        end
    end

`ifdef SPIKE_ARB_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt [N_CH];

    always_ff @(posedge clk or negedge rst_n) begin : drop_counters
        if (!rst_n) begin
            for (int unsigned c = 0; c < N_CH; c++) drop_cnt[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (drop_clr) begin
                    drop_cnt[c] <= '0;
                end else if (!flush && drop[c] && (drop_cnt[c] != '1)) begin
                    drop_cnt[c] <= drop_cnt[c] + 1'b1;
                end
            end
        end
    end

    assign drop_count = (32'(drop_sel) < N_CH) ? drop_cnt[drop_sel] : '0;
`else
    logic unused_drop_sel;

    assign unused_drop_sel = ^drop_sel;
    assign drop_count      = '0;
`endif

endmodule

// File: doc/spike_event_arbiter.md
# spike_event_arbiter

Merges per-channel spike pulses from the 16-channel cochlear front end into the single `spike_valid`/`channel_id` event stream consumed by the training and recording controller. A pending bit is latched per channel, and one event per cycle is granted in round-robin order through a valid/ready handshake. Spikes that collide with an already-pending event on the same channel are dropped and counted. The block sits between the front-end spike generators and the button/LED training state machine.

## Interface
- `N_CH`, 16, number of spike channels
- `CH_W`, 4, channel index width; must satisfy 2^CH_W >= N_CH
- `DROP_W`, 8, width of each per-channel saturating drop counter
- `clk`  in  1  clock
- `rst_n`  in  1  reset: asynchronous, active-low
- `spike_in`  in  N_CH  single-cycle spike pulses; bit c = channel c; synchronous to clk
- `ch_enable`  in  N_CH  channel mask; spikes on a disabled channel are ignored and never counted
- `flush`  in  1  synchronous clear of all pending events and of the output register
- `out_ready`  in  1  downstream accepts the current event
- `out_valid`  out  1  event present on `out_channel`
- `out_channel`  out  CH_W  channel index of the current event
- `pending`  out  N_CH  current pending bits
- `any_drop`  out  1  sticky flag: at least one spike dropped since reset or `drop_clr`
- `drop_sel`  in  CH_W  channel select for the drop-count read
- `drop_count`  out  DROP_W  drop counter of channel `drop_sel`; combinational read
- `drop_clr`  in  1  synchronous clear of all drop counters and of `any_drop`

## Operation
- Request vector: `req = pending | (spike_in & ch_enable)`. A spike arriving this cycle can be granted this cycle (bypass).
- Load condition: `load = !out_valid || out_ready`. When `load` is true and `req != 0`:
  - the arbiter picks the first set bit of `req`, searching upward from `rr_ptr` and wrapping modulo N_CH;
  - the output register takes that index and `out_valid` is set to 1;
  - `rr_ptr` becomes (grant + 1) mod N_CH.
- When `load` is true and `req == 0`: `out_valid` becomes 0.
- When `load` is false: `out_valid`, `out_channel` and `rr_ptr` hold.
- Pending update for each channel c, where g = grant this cycle:
  - `pending[c]_next = (pending[c] & ~g[c]) | (spike_in[c] & ch_enable[c] & ~(g[c] & ~pending[c]))`.
  - If a pending channel is granted and a new spike arrives on it in the same cycle, the new spike re-arms pending. It is not a drop.
- Drop: `spike_in[c] & ch_enable[c] & pending[c] & ~g[c]`.
  - The channel's counter increments and saturates at 2^DROP_W − 1.
  - `any_drop` is set.
- An event held in the output register awaiting `out_ready` is not pending. A new spike on that channel sets pending normally.
- Clearing `ch_enable[c]` does not clear an already-pending event on channel c. That event is still granted.
- `flush` has priority over everything except reset. On the next edge:
  - `pending` is 0 and `out_valid` is 0;
  - `spike_in` in the flush cycle is discarded and is not counted as a drop;
  - `rr_ptr` holds, and the drop counters hold.
- `drop_clr` in the same cycle as a drop: the clear wins, and the counter becomes 0.
- Reset values: `out_valid`=0, `out_channel`=0, `pending`=0, `rr_ptr`=0, `any_drop`=0, all drop counters=0.

## Timing
- Latency: a spike sampled at edge k on an idle arbiter produces `out_valid`=1 and `out_channel`=c after edge k.
- Throughput: one event per cycle while `out_ready`=1.
- Handshake:
  - transfer occurs at an edge where `out_valid && out_ready`;
  - `out_channel` stays stable while `out_valid && !out_ready`;
  - `out_valid` never drops without a transfer, except on `flush` or reset.
- Fairness: with all N_CH channels continuously requesting and `out_ready`=1, each channel is granted exactly once every N_CH cycles.
- Reset is asynchronous and may occur mid-handshake. All state clears immediately, and no event is replayed.

## Configuration
- `SPIKE_ARB_DROP_CNT_EN` defined: the per-channel drop counters, `drop_sel` read mux, and `drop_clr` path are built.
- Not defined: no counters are built, and `drop_count` is tied to 0. The `any_drop` sticky flag and its `drop_clr` clear remain.

## Test plan
- Single spike, ch 5, `out_ready`=1 → `out_valid`=1 and `out_channel`=5 for exactly one cycle after the sampling edge; `pending`=0 afterward.
- `spike_in`=0xFFFF for one cycle, `out_ready`=1, `rr_ptr`=0 → channels 0,1,…,15 granted on 16 consecutive cycles; `pending` then 0; no drops.
- Ch 3 spike held with `out_ready`=0 for 4 cycles, ch 3 spiking every cycle → `out_channel`=3 held stable; pending[3] is set by the second spike and the remaining 2 spikes are dropped; `drop_count`(3)=2; `any_drop`=1.
- 300 colliding spikes on ch 9 → `drop_count`(9) saturates at 255; then `drop_clr` → counter 0 and `any_drop`=0.
- `flush` with `pending`=0x00F0, `out_valid`=1, and a simultaneous spike on ch 2 → next cycle `pending`=0, `out_valid`=0, no drop counted.
- `ch_enable`=0xFFFE, spike on ch 0 → no event, no drop; assert `rst_n` low mid-handshake → all outputs return to reset values asynchronously.
